// File: rtl/multitrack_memory_pkg.sv
// ============================================================================
// multitrack_memory_pkg -- shared state encodings and default sizes
// Rev 1.0
// ============================================================================
`default_nettype none

package multitrack_memory_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DEPTH  = 64;
  localparam int DEFAULT_TRACKS = 4;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_REC  = 1'b1
  } rec_state_t;

  typedef enum logic [0:0] {
    P_IDLE = 1'b0,
    P_PLAY = 1'b1
  } play_state_t;

endpackage

`default_nettype wire

// File: rtl/multitrack_memory_track_bank.sv
// ============================================================================
// track_bank -- one track: simple dual-port RAM, sync write, 2-stage read
// Rev 1.0
// ============================================================================
`default_nettype none

module track_bank
  import multitrack_memory_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  input  logic              rd_keep,
  input  logic              out_load,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] stage_data;
  logic             stage_keep;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Stage 1 reads the array on the tick edge, so a same-edge write is not seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_data <= '0;
      stage_keep <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (rd_en) begin
        stage_data <= mem[rd_addr];
        stage_keep <= rd_keep;
      end
      rd_data <= (out_load && stage_keep) ? stage_data : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multitrack_memory.sv
// ============================================================================
// multitrack_memory -- multi-track sample recorder/player with overdub
// Optional: MULTITRACK_LOOP_EN makes playback wrap at the end point.  Rev 1.0
// ============================================================================
`default_nettype none

module multitrack_memory
  import multitrack_memory_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int TRACKS = DEFAULT_TRACKS,
  localparam int AWIDTH = $clog2(DEPTH),
  localparam int TWIDTH = $clog2(TRACKS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    rec_start,
  input  logic                    rec_stop,
  input  logic [TWIDTH-1:0]       rec_track,
  input  logic                    rec_valid,
  input  logic [WIDTH-1:0]        rec_data,
  output logic                    rec_busy,
  output logic                    rec_full,
  input  logic                    play_start,
  input  logic                    play_stop,
  input  logic                    play_tick,
  output logic                    play_busy,
  output logic                    play_valid,
  output logic [TRACKS*WIDTH-1:0] play_data,
  output logic                    play_done
);

  localparam int LWIDTH = AWIDTH + 1;

`ifdef MULTITRACK_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  rec_state_t          rec_state, rec_state_next;
  play_state_t         play_state, play_state_next;
  logic [TWIDTH-1:0]   rec_trk;
  logic [AWIDTH-1:0]   wr_addr;
  logic [AWIDTH-1:0]   rd_addr;
  logic [LWIDTH-1:0]   lens [TRACKS];
  logic [LWIDTH-1:0]   max_len;
  logic [TRACKS-1:0]   keep;
  logic                rec_begin, wr_en, len_load, auto_stop;
  logic [LWIDTH-1:0]   len_value;
  logic                play_begin, tick_fire, at_end;
  logic                tick_s1, done_s1, valid_q, done_q;
  logic [TRACKS*WIDTH-1:0] bank_data;

  // ---------------- recorder ----------------
  always_comb begin
    rec_state_next = rec_state;
    rec_begin      = 1'b0;
    wr_en          = 1'b0;
    len_load       = 1'b0;
    len_value      = '0;
    auto_stop      = 1'b0;
    if (cs) begin
      unique case (rec_state)
        R_IDLE: begin
          if (rec_start && !rec_stop) begin
            rec_state_next = R_REC;
            rec_begin      = 1'b1;
          end
        end
        R_REC: begin
          wr_en = rec_valid;
          if (rec_valid && (wr_addr == AWIDTH'(DEPTH - 1))) begin
            auto_stop      = 1'b1;
            len_load       = 1'b1;
            len_value      = LWIDTH'(DEPTH);
            rec_state_next = R_IDLE;
          end else if (rec_stop) begin
            // A sample strobed with stop is written first and counted.
            len_load       = 1'b1;
            len_value      = {1'b0, wr_addr} + {{AWIDTH{1'b0}}, rec_valid};
            rec_state_next = R_IDLE;
          end
        end
        default: rec_state_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rec_state <= R_IDLE;
    end else begin
      rec_state <= rec_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rec_trk  <= '0;
      wr_addr  <= '0;
      rec_full <= 1'b0;
      for (int t = 0; t < TRACKS; t++) begin
        lens[t] <= '0;
      end
    end else begin
      rec_full <= auto_stop;
      if (rec_begin) begin
        rec_trk <= rec_track;
        wr_addr <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + AWIDTH'(1);
      end
      if (len_load) begin
        lens[rec_trk] <= len_value;
      end
    end
  end

  // ---------------- player ----------------
  always_comb begin
    max_len = '0;
    keep    = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (lens[t] > max_len) begin
        max_len = lens[t];
      end
      keep[t] = lens[t] > {1'b0, rd_addr};
    end
  end

  always_comb begin
    play_state_next = play_state;
    play_begin      = 1'b0;
    tick_fire       = 1'b0;
    // >= also covers a take being shortened underneath an active playback.
    at_end          = ({1'b0, rd_addr} + LWIDTH'(1)) >= max_len;
    if (cs) begin
      unique case (play_state)
        P_IDLE: begin
          if (play_start && (max_len != '0)) begin
            play_state_next = P_PLAY;
            play_begin      = 1'b1;
          end
        end
        P_PLAY: begin
          if (play_stop) begin
            play_state_next = P_IDLE;
          end else if (play_tick) begin
            tick_fire = 1'b1;
            if (at_end && !LOOP_EN) begin
              play_state_next = P_IDLE;
            end
          end
        end
        default: play_state_next = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      play_state <= P_IDLE;
    end else begin
      play_state <= play_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
      tick_s1 <= 1'b0;
      done_s1 <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (play_begin) begin
        rd_addr <= '0;
      end else if (tick_fire) begin
        rd_addr <= at_end ? '0 : rd_addr + AWIDTH'(1);
      end
      tick_s1 <= tick_fire;
      done_s1 <= tick_fire && at_end;
      valid_q <= tick_s1 && cs;
      done_q  <= done_s1 && cs;
    end
  end

  for (genvar t = 0; t < TRACKS; t++) begin : g_track
    track_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en && (rec_trk == TWIDTH'(t))),
      .wr_addr  (wr_addr),
      .wr_data  (rec_data),
      .rd_en    (tick_fire),
      .rd_addr  (rd_addr),
      .rd_keep  (keep[t]),
      .out_load (tick_s1 && cs),
      .rd_data  (bank_data[t*WIDTH +: WIDTH])
    );
  end

  assign rec_busy   = (rec_state == R_REC);
  assign play_busy  = (play_state == P_PLAY);
  assign play_valid = cs && valid_q;
  assign play_done  = cs && done_q;
  assign play_data  = cs ? bank_data : '0;

endmodule

`default_nettype wire
